fp_div_arbiter: RTL and testbench

FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

---
 rtl/fp_div_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fp_div_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_arbiter.sv
// Two-port round-robin arbiter in front of a single-precision divider.
// Restoring mantissa division, truncating normalisation, registered response.
module fp_div_arbiter #(
  parameter logic RR_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_exc,
  output logic        rsp_id
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    RESP
  } state_t;

  state_t      state;
  logic        last;
  logic        id_r;
  logic        sgn;
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [23:0] mb;
  logic [25:0] rem;
  logic [24:0] quo;
  logic [4:0]  cnt;

  logic        idle;
  logic        acc;
  logic        acc_id;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_s;
  logic        a_zero;
  logic        b_zero;

  logic        ge;
  logic [23:0] diff;
  logic [25:0] rem_nxt;

  logic        adj;
  logic [22:0] mant;
  logic [9:0]  e;
  logic        ovf;
  logic        unf;

  // Grant: last-served pointer breaks ties, reset forces both low.
  assign idle = (state == IDLE);
  assign req0_ready = ~rst & idle & req0_valid
                    & (~req1_valid | last);
  assign req1_ready = ~rst & idle & req1_valid
                    & (~req0_valid | ~last);

  // Select the granted operands and classify zero operands.
  always_comb begin
    acc    = req0_ready | req1_ready;
    acc_id = req1_ready;
    in_a   = acc_id ? req1_a : req0_a;
    in_b   = acc_id ? req1_b : req0_b;
    in_s   = in_a[31] ^ in_b[31];
    b_zero = (in_b[30:0] == 31'd0);
    a_zero = (in_a[30:0] == 31'd0);
  end

  // One restoring step; remainder stays below 2*mb so 26 bits suffice.
  always_comb begin
    ge      = (rem >= {2'b00, mb});
    diff    = rem[23:0] - mb;
    rem_nxt = ge ? {1'b0, diff, 1'b0}
                 : {rem[24:0], 1'b0};
  end

  // Normalise the 25-bit quotient and range-check the exponent.
  always_comb begin
    adj  = ~quo[24];
    mant = quo[24] ? quo[23:1] : quo[22:0];
    e    = {2'b00, ea} - {2'b00, eb}
         + 10'd127 - {9'd0, adj};
    ovf  = ~e[9] & (e >= 10'd255);
    unf  = e[9] | (e == 10'd0);
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= RR_INIT;
      id_r       <= 1'b0;
      sgn        <= 1'b0;
      ea         <= 8'd0;
      eb         <= 8'd0;
      mb         <= 24'd0;
      rem        <= 26'd0;
      quo        <= 25'd0;
      cnt        <= 5'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      rsp_exc    <= 2'b00;
      rsp_id     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            last <= acc_id;
            id_r <= acc_id;
            sgn  <= in_s;
            ea   <= in_a[30:23];
            eb   <= in_b[30:23];
            mb   <= {1'b1, in_b[22:0]};
            rem  <= {2'b01, in_a[22:0]};
            quo  <= 25'd0;
            cnt  <= 5'd0;
            if (b_zero) begin
              rsp_result <= {in_s, 8'hFF, 23'd0};
              rsp_exc    <= 2'b11;
              rsp_id     <= acc_id;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else if (a_zero) begin
              rsp_result <= {in_s, 31'd0};
              rsp_exc    <= 2'b00;
              rsp_id     <= acc_id;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              state <= DIV;
            end
          end
        end
        DIV: begin
          quo <= {quo[23:0], ge};
          rem <= rem_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24) begin
            state <= NORM;
          end
        end
        NORM: begin
          if (ovf) begin
            rsp_result <= {sgn, 8'hFF, 23'd0};
            rsp_exc    <= 2'b10;
          end else if (unf) begin
            rsp_result <= {sgn, 31'd0};
            rsp_exc    <= 2'b01;
          end else begin
            rsp_result <= {sgn, e[7:0], mant};
            rsp_exc    <= 2'b00;
          end
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter with an arithmetic reference model,
// per-cycle scoreboard compare and literal expectations.
module tb_fp_div_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_exc;
  logic        rsp_id;

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  exc;
    logic        id;
    longint      due;
  } exp_t;

  exp_t sbq[$];

  fp_div_arbiter #(.RR_INIT(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .req0_valid(req0_valid),
    .req0_a(req0_a),
    .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_a(req1_a),
    .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_exc(rsp_exc),
    .rsp_id(rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Quotient from integer division of the scaled mantissas.
  function automatic logic [33:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    logic        s;
    longint      ma;
    longint      mbv;
    longint      q;
    logic [24:0] qq;
    logic [22:0] mant;
    int          adj;
    int          e;
    logic [7:0]  e8;
    s = a[31] ^ b[31];
    if (b[30:0] == 31'd0) return {2'b11, s, 8'hFF, 23'd0};
    if (a[30:0] == 31'd0) return {2'b00, s, 31'd0};
    ma  = longint'({1'b1, a[22:0]});
    mbv = longint'({1'b1, b[22:0]});
    q   = (ma * 64'sd16777216) / mbv;
    qq  = q[24:0];
    if (q >= 64'sd16777216) begin
      adj  = 0;
      mant = qq[23:1];
    end else begin
      adj  = 1;
      mant = qq[22:0];
    end
    e = int'(a[30:23]) - int'(b[30:23]) + 127 - adj;
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    e8 = e[7:0];
    return {2'b00, s, e8, mant};
  endfunction

  function automatic exp_t mk(input logic [31:0] a,
                              input logic [31:0] b,
                              input logic id);
    exp_t        x;
    logic [33:0] m;
    logic        sp;
    m     = model(a, b);
    sp    = (a[30:0] == 31'd0) || (b[30:0] == 31'd0);
    x.res = m[31:0];
    x.exc = m[33:32];
    x.id  = id;
    x.due = cyc + 1 + (sp ? 0 : 26);
    return x;
  endfunction

  logic        prev_v;
  logic        prev_rdy;
  logic [31:0] prev_res;
  logic [1:0]  prev_exc;
  logic        prev_id;

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin
    total++;
    if (req0_ready && req1_ready) begin
      bad++;
      $display("FAIL both_ready got=11 want=not11");
    end
    if (rst) begin
      chk("ready_in_rst", {30'd0, req1_ready, req0_ready}, 32'd0);
      sbq.delete();
      prev_v = 1'b0;
    end else begin
      if (req0_valid && req0_ready)
        sbq.push_back(mk(req0_a, req0_b, 1'b0));
      if (req1_valid && req1_ready)
        sbq.push_back(mk(req1_a, req1_b, 1'b1));
      if (rsp_valid) begin
        if (!prev_v) begin
          total++;
          if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rsp got=valid want=none");
          end else begin
            chk("latency", 32'(cyc), 32'(sbq[0].due));
          end
        end else if (!prev_rdy) begin
          chk("hold_res", rsp_result, prev_res);
          chk("hold_exc", {30'd0, rsp_exc}, {30'd0, prev_exc});
          chk("hold_id", {31'd0, rsp_id}, {31'd0, prev_id});
        end
        if (sbq.size() != 0) begin
          chk("sb_res", rsp_result, sbq[0].res);
          chk("sb_exc", {30'd0, rsp_exc}, {30'd0, sbq[0].exc});
          chk("sb_id", {31'd0, rsp_id}, {31'd0, sbq[0].id});
          if (rsp_ready) void'(sbq.pop_front());
        end
      end
      prev_v   = rsp_valid;
      prev_rdy = rsp_ready;
      prev_res = rsp_result;
      prev_exc = rsp_exc;
      prev_id  = rsp_id;
    end
  end

  task automatic send(input int p,
                      input logic [31:0] a,
                      input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    if (p == 0) begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout got=none want=ready port=%0d", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name,
                          input logic [31:0] res,
                          input logic [1:0] exc,
                          input logic id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout got=none want=rsp", name);
    end else begin
      chk({name, "_res"}, rsp_result, res);
      chk({name, "_exc"}, {30'd0, rsp_exc}, {30'd0, exc});
      chk({name, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fair_res [4];
  logic        fair_id  [4];
  int          got;

  initial begin
    fair_res[0] = 32'h40400000; fair_id[0] = 1'b0;
    fair_res[1] = 32'h3EAAAAAA; fair_id[1] = 1'b1;
    fair_res[2] = 32'h40400000; fair_id[2] = 1'b0;
    fair_res[3] = 32'h3EAAAAAA; fair_id[3] = 1'b1;

    rst        = 1'b1;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_a     = 32'h40C00000;
    req0_b     = 32'h40000000;
    req1_valid = 1'b1;
    req1_a     = 32'h3F800000;
    req1_b     = 32'h40400000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_res", rsp_result, 32'd0);
    chk("rst_exc", {30'd0, rsp_exc}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    rst = 1'b0;

    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        chk("fair_id", {31'd0, rsp_id}, {31'd0, fair_id[got]});
        chk("fair_res", rsp_result, fair_res[got]);
        chk("fair_exc", {30'd0, rsp_exc}, 32'd0);
        got++;
        if (got == 4) break;
      end
    end
    total++;
    if (got != 4) begin
      bad++;
      $display("FAIL fair_timeout got=%0d want=4", got);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    send(0, 32'h3F800000, 32'h00000000);
    wait_rsp("div0", 32'h7F800000, 2'b11, 1'b0);
    send(1, 32'h80000000, 32'h40000000);
    wait_rsp("zero_a", 32'h80000000, 2'b00, 1'b1);
    send(0, 32'h7F000000, 32'h00800000);
    wait_rsp("ovf", 32'h7F800000, 2'b10, 1'b0);
    send(1, 32'h00800000, 32'h7F000000);
    wait_rsp("unf", 32'h00000000, 2'b01, 1'b1);
    send(1, 32'hC0C00000, 32'h40000000);
    wait_rsp("neg", 32'hC0400000, 2'b00, 1'b1);

    rsp_ready = 1'b0;
    send(0, 32'h40C00000, 32'h40000000);
    req1_a     = 32'h3F800000;
    req1_b     = 32'h40400000;
    req1_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        break;
      end
    end
    chk("stall_seen", got, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_res", rsp_result, 32'h40400000);
      chk("stall_rdy1", {31'd0, req1_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req1_ready) begin
        got = 1;
        break;
      end
    end
    chk("after_stall_acc", got, 1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    wait_rsp("after_stall", 32'h3EAAAAAA, 2'b00, 1'b1);

    send(0, 32'h40C00000, 32'h40000000);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("abort_quiet", {31'd0, rsp_valid}, 32'd0);
    end
    send(1, 32'h3F800000, 32'h40400000);
    wait_rsp("post_rst", 32'h3EAAAAAA, 2'b00, 1'b1);

    repeat (5) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
